id_ex_stage: RTL and testbench

//  Instruction-decode stage plus ID/EX pipeline latch of the 5-stage MIPS core.

---
 rtl/id_ex_stage.sv | 104 ++++++++++
 tb/tb_id_ex_stage.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// Decode stage and ID/EX pipeline latch: register file with write-through bypass,
// load-use hazard detection, immediate extension and the registered EX-side fields.
module id_ex_stage #(
  parameter int len_data      = 32,
  parameter int len_reg_addr  = 5,
  parameter int len_ctrl      = 10,
  parameter int ctrl_mem_read = 3,
  parameter int ctrl_zext     = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [len_data-1:0]     in_instruction,
  input  logic [len_data-1:0]     in_pc,
  input  logic [len_ctrl-1:0]     in_ctrl,
  input  logic                    in_flush,
  input  logic                    in_wb_we,
  input  logic [len_reg_addr-1:0] in_wb_addr,
  input  logic [len_data-1:0]     in_wb_data,
  input  logic [len_reg_addr-1:0] in_debug_addr,
  output logic                    out_stall_flag,
  output logic [len_data-1:0]     out_rs_data,
  output logic [len_data-1:0]     out_rt_data,
  output logic [len_data-1:0]     out_imm,
  output logic [len_reg_addr-1:0] out_rs,
  output logic [len_reg_addr-1:0] out_rt,
  output logic [len_reg_addr-1:0] out_rd,
  output logic [len_ctrl-1:0]     out_ctrl,
  output logic [len_data-1:0]     out_pc,
  output logic                    out_halt_flag_id,
  output logic [len_data-1:0]     out_debug_data
);

  localparam int NREG = 2 ** len_reg_addr;

  logic [len_data-1:0]     r_regs [NREG];
  logic [len_reg_addr-1:0] w_rs_addr;
  logic [len_reg_addr-1:0] w_rt_addr;
  logic [len_reg_addr-1:0] w_rd_addr;
  logic [len_data-1:0]     w_rs_data;
  logic [len_data-1:0]     w_rt_data;
  logic [len_data-1:0]     w_imm;
  logic                    w_hazard;
  logic                    w_halt;
  logic                    w_wb_valid;

  assign w_rs_addr  = in_instruction[21 +: len_reg_addr];
  assign w_rt_addr  = in_instruction[16 +: len_reg_addr];
  assign w_rd_addr  = in_instruction[11 +: len_reg_addr];
  assign w_halt     = (in_instruction[31:26] == 6'b111111);
  assign w_wb_valid = in_wb_we && (in_wb_addr != '0);

  // Reads see a same-cycle writeback so WB->ID needs no extra forwarding path.
  assign w_rs_data = (w_rs_addr == '0) ? '0 :
                     (w_wb_valid && in_wb_addr == w_rs_addr) ? in_wb_data : r_regs[w_rs_addr];
  assign w_rt_data = (w_rt_addr == '0) ? '0 :
                     (w_wb_valid && in_wb_addr == w_rt_addr) ? in_wb_data : r_regs[w_rt_addr];
  assign out_debug_data = (in_debug_addr == '0) ? '0 :
                          (w_wb_valid && in_wb_addr == in_debug_addr) ? in_wb_data
                                                                      : r_regs[in_debug_addr];

  assign w_imm = in_ctrl[ctrl_zext] ? {{(len_data-16){1'b0}}, in_instruction[15:0]}
                                    : {{(len_data-16){in_instruction[15]}}, in_instruction[15:0]};

  assign w_hazard = out_ctrl[ctrl_mem_read] && (out_rt != '0) &&
                    ((out_rt == w_rs_addr) || (out_rt == w_rt_addr));
  assign out_stall_flag = w_hazard && !in_flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (w_wb_valid) begin
      r_regs[in_wb_addr] <= in_wb_data;
    end
  end

  // Flush and stall both inject a bubble; only the normal path updates the data fields.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_rs_data      <= '0;
      out_rt_data      <= '0;
      out_imm          <= '0;
      out_rs           <= '0;
      out_rt           <= '0;
      out_rd           <= '0;
      out_ctrl         <= '0;
      out_pc           <= '0;
      out_halt_flag_id <= 1'b0;
    end else if (in_flush || w_hazard) begin
      out_ctrl         <= '0;
      out_halt_flag_id <= 1'b0;
    end else begin
      out_rs_data      <= w_rs_data;
      out_rt_data      <= w_rt_data;
      out_imm          <= w_imm;
      out_rs           <= w_rs_addr;
      out_rt           <= w_rt_addr;
      out_rd           <= w_rd_addr;
      out_ctrl         <= in_ctrl;
      out_pc           <= in_pc;
      out_halt_flag_id <= w_halt;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: bypass, r0, load-use stall, flush, immediates, halt, reset.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_instruction;
  logic [31:0] in_pc;
  logic [9:0]  in_ctrl;
  logic        in_flush;
  logic        in_wb_we;
  logic [4:0]  in_wb_addr;
  logic [31:0] in_wb_data;
  logic [4:0]  in_debug_addr;
  logic        out_stall_flag;
  logic [31:0] out_rs_data;
  logic [31:0] out_rt_data;
  logic [31:0] out_imm;
  logic [4:0]  out_rs;
  logic [4:0]  out_rt;
  logic [4:0]  out_rd;
  logic [9:0]  out_ctrl;
  logic [31:0] out_pc;
  logic        out_halt_flag_id;
  logic [31:0] out_debug_data;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [9:0] CTRL_ALU  = 10'h003;
  localparam logic [9:0] CTRL_LW   = 10'h00B;
  localparam logic [9:0] CTRL_ZEXT = 10'h013;

  id_ex_stage #(.len_data(32), .len_reg_addr(5), .len_ctrl(10),
                .ctrl_mem_read(3), .ctrl_zext(4)) dut (
    .clk(clk), .reset(reset),
    .in_instruction(in_instruction), .in_pc(in_pc), .in_ctrl(in_ctrl),
    .in_flush(in_flush), .in_wb_we(in_wb_we), .in_wb_addr(in_wb_addr),
    .in_wb_data(in_wb_data), .in_debug_addr(in_debug_addr),
    .out_stall_flag(out_stall_flag), .out_rs_data(out_rs_data),
    .out_rt_data(out_rt_data), .out_imm(out_imm), .out_rs(out_rs),
    .out_rt(out_rt), .out_rd(out_rd), .out_ctrl(out_ctrl), .out_pc(out_pc),
    .out_halt_flag_id(out_halt_flag_id), .out_debug_data(out_debug_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rtype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd);
    return {op, rs, rt, rd, 11'd0};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  initial begin
    reset = 1'b1; in_instruction = '0; in_pc = '0; in_ctrl = '0; in_flush = 1'b0;
    in_wb_we = 1'b0; in_wb_addr = '0; in_wb_data = '0; in_debug_addr = 5'd5;
    #12;
    check("rst_ctrl", 32'(out_ctrl), 32'h0);
    check("rst_rs_data", out_rs_data, 32'h0);
    check("rst_pc", out_pc, 32'h0);
    check("rst_stall", 32'(out_stall_flag), 32'h0);
    check("rst_dbg", out_debug_data, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // 1: writeback bypass into decode, then the file holds the value
    in_wb_we = 1'b1; in_wb_addr = 5'd5; in_wb_data = 32'hDEADBEEF;
    in_instruction = rtype(6'h00, 5'd5, 5'd0, 5'd7); in_ctrl = CTRL_ALU; in_pc = 32'd1;
    #1;
    check("dbg_bypass", out_debug_data, 32'hDEADBEEF);
    tick();
    check("t1_rs_data", out_rs_data, 32'hDEADBEEF);
    check("t1_rt_data", out_rt_data, 32'h0);
    check("t1_rd", 32'(out_rd), 32'd7);
    check("t1_pc", out_pc, 32'd1);
    check("t1_ctrl", 32'(out_ctrl), 32'(CTRL_ALU));
    in_wb_we = 1'b0;
    #1;
    check("t1_dbg_file", out_debug_data, 32'hDEADBEEF);

    // 2: r0 ignores writes and always reads zero
    in_wb_we = 1'b1; in_wb_addr = 5'd0; in_wb_data = 32'h1234; in_debug_addr = 5'd0;
    in_instruction = rtype(6'h00, 5'd0, 5'd5, 5'd8); in_pc = 32'd2;
    #1;
    check("t2_dbg_r0_bypass", out_debug_data, 32'h0);
    tick();
    in_wb_we = 1'b0;
    check("t2_rs_r0", out_rs_data, 32'h0);
    check("t2_rt_r5", out_rt_data, 32'hDEADBEEF);
    #1;
    check("t2_dbg_r0", out_debug_data, 32'h0);

    // 3: load-use stall for exactly one cycle
    in_instruction = itype(6'h23, 5'd0, 5'd3, 16'd4); in_ctrl = CTRL_LW; in_pc = 32'd3;
    tick();
    check("t3_lw_rt", 32'(out_rt), 32'd3);
    check("t3_lw_imm", out_imm, 32'd4);
    in_instruction = rtype(6'h00, 5'd1, 5'd3, 5'd4); in_ctrl = CTRL_ALU; in_pc = 32'd10;
    #1;
    check("t3_stall", 32'(out_stall_flag), 32'h1);
    tick();
    check("t3_bubble_ctrl", 32'(out_ctrl), 32'h0);
    check("t3_bubble_pc_hold", out_pc, 32'd3);
    check("t3_bubble_rt_hold", 32'(out_rt), 32'd3);
    check("t3_stall_drop", 32'(out_stall_flag), 32'h0);
    tick();
    check("t3_add_ctrl", 32'(out_ctrl), 32'(CTRL_ALU));
    check("t3_add_rd", 32'(out_rd), 32'd4);
    check("t3_add_pc", out_pc, 32'd10);

    // lw to r0 never stalls
    in_instruction = itype(6'h23, 5'd1, 5'd0, 16'd0); in_ctrl = CTRL_LW; in_pc = 32'd11;
    tick();
    in_instruction = rtype(6'h00, 5'd0, 5'd0, 5'd9); in_ctrl = CTRL_ALU; in_pc = 32'd12;
    #1;
    check("t3_r0_nostall", 32'(out_stall_flag), 32'h0);
    tick();
    check("t3_r0_latch_pc", out_pc, 32'd12);

    // 4: flush overrides the hazard, single bubble only
    in_instruction = itype(6'h23, 5'd0, 5'd3, 16'd8); in_ctrl = CTRL_LW; in_pc = 32'd20;
    tick();
    in_instruction = rtype(6'h00, 5'd3, 5'd2, 5'd6); in_ctrl = CTRL_ALU; in_pc = 32'd21;
    in_flush = 1'b1;
    #1;
    check("t4_flush_nostall", 32'(out_stall_flag), 32'h0);
    tick();
    in_flush = 1'b0;
    check("t4_flush_ctrl", 32'(out_ctrl), 32'h0);
    check("t4_flush_pc_hold", out_pc, 32'd20);
    in_instruction = rtype(6'h00, 5'd3, 5'd2, 5'd6); in_pc = 32'd22;
    #1;
    check("t4_after_nostall", 32'(out_stall_flag), 32'h0);
    tick();
    check("t4_after_ctrl", 32'(out_ctrl), 32'(CTRL_ALU));
    check("t4_after_pc", out_pc, 32'd22);

    // 5: sign vs zero extension
    in_instruction = itype(6'h08, 5'd0, 5'd1, 16'h8000); in_ctrl = CTRL_ALU;
    tick();
    check("t5_sext", out_imm, 32'hFFFF8000);
    in_ctrl = CTRL_ZEXT;
    tick();
    check("t5_zext", out_imm, 32'h00008000);
    in_instruction = itype(6'h08, 5'd0, 5'd1, 16'h7FFF); in_ctrl = CTRL_ALU;
    tick();
    check("t5_sext_pos", out_imm, 32'h00007FFF);

    // 6: halt, then stall pending, then async reset mid-cycle
    in_instruction = 32'hFC000000; in_ctrl = 10'h001; in_pc = 32'd30;
    tick();
    check("t6_halt", 32'(out_halt_flag_id), 32'h1);
    in_instruction = itype(6'h23, 5'd0, 5'd4, 16'd0); in_ctrl = CTRL_LW; in_pc = 32'd31;
    tick();
    check("t6_halt_clear", 32'(out_halt_flag_id), 32'h0);
    in_instruction = rtype(6'h00, 5'd4, 5'd0, 5'd1); in_ctrl = CTRL_ALU;
    #1;
    check("t6_stall_pre", 32'(out_stall_flag), 32'h1);
    #1;
    reset = 1'b1;
    #1;
    check("t6_rst_stall", 32'(out_stall_flag), 32'h0);
    check("t6_rst_ctrl", 32'(out_ctrl), 32'h0);
    check("t6_rst_pc", out_pc, 32'h0);
    check("t6_rst_imm", out_imm, 32'h0);
    check("t6_rst_rt", 32'(out_rt), 32'h0);
    in_debug_addr = 5'd5;
    #1;
    check("t6_rst_file", out_debug_data, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
